// File: rtl/ceespu_writeback.sv
// ceespu_writeback: write-side front end for ceespu_regfile.
// Merges ALU and load results into an in-order FIFO and drains one
// register-file write per cycle. It also exports a mask of registers
// that still have a write in flight, for the hazard logic.
module ceespu_writeback #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic                     I_alu_valid,
    input  logic [SEL_W-1:0]         I_alu_sel,
    input  logic [DATA_W-1:0]        I_alu_data,
    output logic                     O_alu_ready,
    input  logic                     I_mem_valid,
    input  logic [SEL_W-1:0]         I_mem_sel,
    input  logic [DATA_W-1:0]        I_mem_data,
    output logic                     O_mem_ready,
    output logic                     O_we,
    output logic [SEL_W-1:0]         O_selD,
    output logic [DATA_W-1:0]        O_dataD,
    output logic [31:0]              O_pending,
    output logic [$clog2(DEPTH):0]   O_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SEL_W-1:0]  sel_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  alu_wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              mem_push;
    logic              alu_push;
    logic              pop;

    // Readiness looks only at the registered occupancy, so valid never
    // feeds ready. The ALU needs one more free slot than the load path
    // so that a simultaneous push of both always fits.
    assign O_mem_ready = I_rst && (count <= CNT_W'(DEPTH - 1));
    assign O_alu_ready = I_rst && (count <= CNT_W'(DEPTH - 2));

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_push = I_mem_valid && O_mem_ready && (I_mem_sel != '0);
    assign alu_push = I_alu_valid && O_alu_ready && (I_alu_sel != '0);

    // Pop decision uses occupancy before this edge's pushes, so a
    // result always spends at least one cycle in the queue.
    assign pop = (count != '0);

    // The load entry is older, so the ALU entry lands one slot behind it.
    assign alu_wr_ptr = wr_ptr + PTR_W'(mem_push);

    assign O_count = count;

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge I_clk) begin
        if (mem_push) begin
            sel_mem[wr_ptr]  <= I_mem_sel;
            data_mem[wr_ptr] <= I_mem_data;
        end
        if (alu_push) begin
            sel_mem[alu_wr_ptr]  <= I_alu_sel;
            data_mem[alu_wr_ptr] <= I_alu_data;
        end
    end

    // Pointer/occupancy bookkeeping and the registered regfile write port.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            O_we    <= 1'b0;
            O_selD  <= '0;
            O_dataD <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
            count  <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                O_we    <= 1'b1;
                O_selD  <= sel_mem[rd_ptr];
                O_dataD <= data_mem[rd_ptr];
            end else begin
                O_we <= 1'b0;
            end
        end
    end

    // Pending mask: every occupied slot plus the write currently on the
    // port. A slot is occupied when its distance from the head is below
    // the occupancy.
    always_comb begin
        logic [PTR_W-1:0] offset;
        O_pending = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (CNT_W'(offset) < count) begin
                O_pending[sel_mem[i]] = 1'b1;
            end
        end
        if (O_we) begin
            O_pending[O_selD] = 1'b1;
        end
        O_pending[0] = 1'b0;
    end

    // Ready rules make overflow impossible; flag it if that ever breaks.
    no_overflow: assert property (@(posedge I_clk) disable iff (!I_rst)
        (int'(count) + int'(mem_push) + int'(alu_push)) <= DEPTH);

endmodule

// File: tb/tb_ceespu_writeback.sv
// Directed self-checking bench for ceespu_writeback.
module tb_ceespu_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_sel;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_sel;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        we;
    logic [4:0]  sel_d;
    logic [31:0] data_d;
    logic [31:0] pending;
    logic [2:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] reg_model [32];
    logic [4:0]  log_sel  [$];
    logic [31:0] log_data [$];
    logic [4:0]  exp_sel  [$];
    logic [31:0] exp_data [$];

    ceespu_writeback #(.DATA_W(32), .SEL_W(5), .DEPTH(4)) dut (
        .I_clk       (clk),
        .I_rst       (rst_n),
        .I_alu_valid (alu_valid),
        .I_alu_sel   (alu_sel),
        .I_alu_data  (alu_data),
        .O_alu_ready (alu_ready),
        .I_mem_valid (mem_valid),
        .I_mem_sel   (mem_sel),
        .I_mem_data  (mem_data),
        .O_mem_ready (mem_ready),
        .O_we        (we),
        .O_selD      (sel_d),
        .O_dataD     (data_d),
        .O_pending   (pending),
        .O_count     (count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register-file model and write log: capture what the port holds at each edge.
    always @(posedge clk) begin
        if (we) begin
            reg_model[sel_d] = data_d;
            log_sel.push_back(sel_d);
            log_data.push_back(data_d);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [4:0] ms, input logic [31:0] md,
                                 input logic av, input logic [4:0] as, input logic [31:0] ad);
        mem_valid = mv;
        mem_sel   = ms;
        mem_data  = md;
        alu_valid = av;
        alu_sel   = as;
        alu_data  = ad;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        log_sel.delete();
        log_data.delete();
        exp_sel.delete();
        exp_data.delete();
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_len"}, 32'(log_sel.size()), 32'(exp_sel.size()));
        for (int i = 0; i < exp_sel.size(); i++) begin
            if (i < log_sel.size()) begin
                checkOutput($sformatf("%s_sel%0d", tag, i), 32'(log_sel[i]), 32'(exp_sel[i]));
                checkOutput($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) reg_model[i] = '0;
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_alu_ready", 32'(alu_ready), 0);
        checkOutput("rst_mem_ready", 32'(mem_ready), 0);
        checkOutput("rst_seld", 32'(sel_d), 0);
        checkOutput("rst_datad", data_d, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_alu_ready", 32'(alu_ready), 1);
        checkOutput("rel_mem_ready", 32'(mem_ready), 1);

        // Test 1: single ALU write, 2-cycle latency and pending tracking
        tick();
        clearLogs();
        applyStimulus(0, 0, 0, 1, 20, 100);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_count_acc", 32'(count), 1);
        checkOutput("t1_we_acc", 32'(we), 0);
        checkOutput("t1_pend_acc", pending, 32'h0010_0000);
        tick();
        checkOutput("t1_we", 32'(we), 1);
        checkOutput("t1_seld", 32'(sel_d), 20);
        checkOutput("t1_datad", data_d, 100);
        checkOutput("t1_pend_wr", pending, 32'h0010_0000);
        checkOutput("t1_count_wr", 32'(count), 0);
        tick();
        checkOutput("t1_we_after", 32'(we), 0);
        checkOutput("t1_pend_after", pending, 0);
        checkOutput("t1_r20", reg_model[20], 100);

        // Test 2: same-cycle mem and ALU to r21, mem first
        applyStimulus(1, 21, 7, 1, 21, 200);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2_count_peak", 32'(count), 2);
        checkOutput("t2_pend", pending, 32'h0020_0000);
        tick();
        checkOutput("t2_we0", 32'(we), 1);
        checkOutput("t2_data0", data_d, 7);
        checkOutput("t2_count1", 32'(count), 1);
        tick();
        checkOutput("t2_we1", 32'(we), 1);
        checkOutput("t2_data1", data_d, 200);
        tick();
        checkOutput("t2_we_end", 32'(we), 0);
        checkOutput("t2_r21", reg_model[21], 200);

        // Test 3: both valids held for 10 cycles; count settles at 3
        clearLogs();
        begin
            int mi;
            int ai;
            mi = 0;
            ai = 0;
            for (int k = 0; k < 10; k++) begin
                applyStimulus(1, 5'(1 + mi), 32'h1000 + 32'(mi), 1, 5'(16 + ai), 32'h2000 + 32'(ai));
                #1;
                checkOutput($sformatf("t3_alu_rdy%0d", k), 32'(alu_ready), (k < 2) ? 1 : 0);
                checkOutput($sformatf("t3_mem_rdy%0d", k), 32'(mem_ready), 1);
                exp_sel.push_back(5'(1 + mi));
                exp_data.push_back(32'h1000 + 32'(mi));
                if (k < 2) begin
                    exp_sel.push_back(5'(16 + ai));
                    exp_data.push_back(32'h2000 + 32'(ai));
                    ai++;
                end
                mi++;
                tick();
                checkOutput($sformatf("t3_count%0d", k), 32'(count), (k == 0) ? 2 : 3);
            end
            applyStimulus(0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 6; k++) tick();
            checkOutput("t3_count_drained", 32'(count), 0);
            checkLog("t3");
        end

        // Test 4: r0 write is accepted and dropped
        clearLogs();
        applyStimulus(0, 0, 0, 1, 0, 32'hDEAD);
        #1;
        checkOutput("t4_alu_ready", 32'(alu_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t4_count", 32'(count), 0);
        checkOutput("t4_pend", pending, 0);
        tick();
        checkOutput("t4_we", 32'(we), 0);
        tick();
        checkOutput("t4_log", 32'(log_sel.size()), 0);

        // Test 5: async reset with 3 entries queued
        applyStimulus(1, 3, 32'h51, 1, 4, 32'h52);
        tick();
        applyStimulus(1, 5, 32'h53, 1, 6, 32'h54);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_count_full", 32'(count), 3);
        checkOutput("t5_we_pre", 32'(we), 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_we_rst", 32'(we), 0);
        checkOutput("t5_count_rst", 32'(count), 0);
        checkOutput("t5_pend_rst", pending, 0);
        checkOutput("t5_alu_rdy_rst", 32'(alu_ready), 0);
        checkOutput("t5_mem_rdy_rst", 32'(mem_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clearLogs();
        #1;
        checkOutput("t5_alu_rdy_rel", 32'(alu_ready), 1);
        checkOutput("t5_mem_rdy_rel", 32'(mem_ready), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("t5_we_stale%0d", k), 32'(we), 0);
        end
        checkOutput("t5_log", 32'(log_sel.size()), 0);

        // Test 6: alternating mem/ALU every cycle, one write per cycle
        clearLogs();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0)
                applyStimulus(1, 5'((k % 8) + 1), 32'h3000 + 32'(k), 0, 0, 0);
            else
                applyStimulus(0, 0, 0, 1, 5'((k % 8) + 1), 32'h3000 + 32'(k));
            exp_sel.push_back(5'((k % 8) + 1));
            exp_data.push_back(32'h3000 + 32'(k));
            tick();
            if (k == 0) begin
                checkOutput("t6_we_fill", 32'(we), 0);
            end else begin
                checkOutput($sformatf("t6_we%0d", k), 32'(we), 1);
                checkOutput($sformatf("t6_data%0d", k), data_d, 32'h3000 + 32'(k - 1));
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_we_last", 32'(we), 1);
        checkOutput("t6_data_last", data_d, 32'h3000 + 32'd19);
        tick();
        checkOutput("t6_we_end", 32'(we), 0);
        tick();
        checkLog("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
